// File: rtl/slip_tx.sv
// SLIP transmit encoder: frames payload bytes with END delimiters and escapes END/ESC.
// Define SLIP_TX_LEAD_END_EN to prefix every frame with an END byte.
module slip_tx #(
  parameter logic [7:0] END_BYTE = 8'hC0,
  parameter logic [7:0] ESC_BYTE = 8'hDB,
  parameter logic [7:0] ESC_END  = 8'hDC,
  parameter logic [7:0] ESC_ESC  = 8'hDD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_rdy,
  output logic       din_ack,
  input  logic       frame,
  output logic [7:0] dout,
  output logic       dout_rdy,
  input  logic       dout_ack,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef SLIP_TX_LEAD_END_EN
  localparam logic [2:0] S_LEAD  = 3'd1;
`endif
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ESC2  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] dout_q, dout_d;
  logic       rdy_q, rdy_d;
  logic [7:0] esc_q, esc_d;
  logic       free;
  logic       xfer_in;
  logic       load;
  logic [7:0] load_byte;

  // The output buffer can take a new byte when empty or when it drains this edge.
  assign free    = !rdy_q | dout_ack;
  assign din_ack = (state_q == S_DATA) & frame & free;
  assign xfer_in = din_rdy & din_ack;

  always_comb begin
    state_d   = state_q;
    esc_d     = esc_q;
    load      = 1'b0;
    load_byte = dout_q;
    case (state_q)
      S_IDLE: begin
        if (frame) begin
`ifdef SLIP_TX_LEAD_END_EN
          state_d = S_LEAD;
`else
          state_d = S_DATA;
`endif
        end
      end
`ifdef SLIP_TX_LEAD_END_EN
      S_LEAD: begin
        if (free) begin
          load      = 1'b1;
          load_byte = END_BYTE;
          state_d   = S_DATA;
        end
      end
`endif
      S_DATA: begin
        if (xfer_in) begin
          load = 1'b1;
          if (din == END_BYTE || din == ESC_BYTE) begin
            load_byte = ESC_BYTE;
            esc_d     = (din == END_BYTE) ? ESC_END : ESC_ESC;
            state_d   = S_ESC2;
          end else begin
            load_byte = din;
          end
        end else if (!frame) begin
          state_d = S_TRAIL;
        end
      end
      // Frame close is deferred here until the escape pair is complete.
      S_ESC2: begin
        if (free) begin
          load      = 1'b1;
          load_byte = esc_q;
          state_d   = S_DATA;
        end
      end
      S_TRAIL: begin
        if (free) begin
          load      = 1'b1;
          load_byte = END_BYTE;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dout_d = load ? load_byte : dout_q;
    if (load) begin
      rdy_d = 1'b1;
    end else if (dout_ack) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dout_q  <= 8'h00;
      rdy_q   <= 1'b0;
      esc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      esc_q   <= esc_d;
    end
  end

  assign dout     = dout_q;
  assign dout_rdy = rdy_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_slip_tx.sv
// Directed bench for slip_tx; expectations follow SLIP_TX_LEAD_END_EN when defined.
module tb_slip_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_rdy;
  logic       din_ack;
  logic       frame;
  logic [7:0] dout;
  logic       dout_rdy;
  logic       dout_ack;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] got[$];
  int         stamp[$];
  logic [7:0] exp_q[$];
  logic [7:0] payload [8];
  int         waits [8];

  slip_tx dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_rdy (din_rdy),
    .din_ack (din_ack),
    .frame   (frame),
    .dout    (dout),
    .dout_rdy(dout_rdy),
    .dout_ack(dout_ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A transfer seen at this negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst && dout_rdy && dout_ack) begin
      got.push_back(dout);
      stamp.push_back(cyc);
    end
  end

  task automatic send_frame(input int n);
    bit ok;
    @(posedge clk); #1;
    frame = 1'b1;
    for (int i = 0; i < n; i++) begin
      din = payload[i];
      din_rdy = 1'b1;
      waits[i] = 0;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (din_ack) begin
          ok = 1'b1;
          break;
        end
        waits[i]++;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL send_timeout byte %0d: din_ack=%b required 1", i, din_ack);
      end
      @(posedge clk); #1;
    end
    din_rdy = 1'b0;
    frame = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = 8'h00; din_rdy = 1'b0; frame = 1'b0; dout_ack = 1'b1;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h required 00", dout); end
    checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL reset_dout_rdy: got %b required 0", dout_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (din_ack !== 1'b0) begin errors++; $display("FAIL reset_din_ack: got %b required 0", din_ack); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_plain();
    got.delete(); stamp.delete();
    exp_q = {};
`ifdef SLIP_TX_LEAD_END_EN
    exp_q.push_back(8'hC0);
`endif
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'hC0);
    dout_ack = 1'b1;
    payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03;
    send_frame(3);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL plain_len: got %0d required %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL plain_byte%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
      for (int i = 0; i < exp_q.size() - 2; i++) begin
        checks++;
        if (stamp[i+1] - stamp[i] != 1) begin
          errors++; $display("FAIL plain_rate%0d: gap %0d required 1", i, stamp[i+1] - stamp[i]);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL plain_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_escape();
    got.delete(); stamp.delete();
    exp_q = {};
`ifdef SLIP_TX_LEAD_END_EN
    exp_q.push_back(8'hC0);
`endif
    exp_q.push_back(8'hDB); exp_q.push_back(8'hDC); exp_q.push_back(8'hDB);
    exp_q.push_back(8'hDD); exp_q.push_back(8'h7E); exp_q.push_back(8'hC0);
    dout_ack = 1'b1;
    payload[0] = 8'hC0; payload[1] = 8'hDB; payload[2] = 8'h7E;
    send_frame(3);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL esc_len: got %0d required %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL esc_byte%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (waits[1] != 1) begin errors++; $display("FAIL esc_stall1: waited %0d required 1", waits[1]); end
    checks++; if (waits[2] != 1) begin errors++; $display("FAIL esc_stall2: waited %0d required 1", waits[2]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] first_exp;
    bit ok;
    got.delete(); stamp.delete();
    exp_q = {};
`ifdef SLIP_TX_LEAD_END_EN
    first_exp = 8'hC0;
    exp_q.push_back(8'hC0);
`else
    first_exp = 8'h55;
`endif
    exp_q.push_back(8'h55); exp_q.push_back(8'hC0);
    @(posedge clk); #1;
    dout_ack = 1'b0; frame = 1'b1; din = 8'h55; din_rdy = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (dout_rdy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_first_load: dout_rdy=%b required 1", dout_rdy); end
`ifndef SLIP_TX_LEAD_END_EN
    din_rdy = 1'b0;
`endif
    checks++; if (dout !== first_exp) begin errors++; $display("FAIL bp_first: got %h required %h", dout, first_exp); end
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if (dout !== first_exp || dout_rdy !== 1'b1 || din_ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: dout=%h rdy=%b din_ack=%b required %h 1 0", t, dout, dout_rdy, din_ack, first_exp);
      end
    end
    @(posedge clk); #1;
    dout_ack = 1'b1;
`ifdef SLIP_TX_LEAD_END_EN
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (din_ack) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: din_ack=%b required 1", din_ack); end
    @(posedge clk); #1;
    din_rdy = 1'b0;
`endif
    frame = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_len: got %0d required %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_empty();
    got.delete(); stamp.delete();
    exp_q = {};
`ifdef SLIP_TX_LEAD_END_EN
    exp_q.push_back(8'hC0);
`endif
    exp_q.push_back(8'hC0);
    dout_ack = 1'b1; din_rdy = 1'b0;
    @(posedge clk); #1;
    frame = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL empty_len: got %0d required %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL empty_byte%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int need;
    bit ok;
    got.delete(); stamp.delete();
`ifdef SLIP_TX_LEAD_END_EN
    need = 2;
`else
    need = 1;
`endif
    dout_ack = 1'b1;
    @(posedge clk); #1;
    frame = 1'b1; din = 8'hC0; din_rdy = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (got.size() >= need) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_reach: got %0d bytes required %0d", got.size(), need); end
    checks++;
    if (got.size() < need || got[need-1] !== 8'hDB) begin
      errors++; $display("FAIL midrst_prefix: last byte %h required db", (got.size() > 0) ? got[got.size()-1] : 8'hxx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00 || dout_rdy !== 1'b0 || busy !== 1'b0 || din_ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: dout=%h rdy=%b busy=%b ack=%b required 00 0 0 0", dout, dout_rdy, busy, din_ack);
    end
    din_rdy = 1'b0; frame = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got.delete(); stamp.delete();
    exp_q = {};
`ifdef SLIP_TX_LEAD_END_EN
    exp_q.push_back(8'hC0);
`endif
    exp_q.push_back(8'hAA); exp_q.push_back(8'hC0);
    payload[0] = 8'hAA;
    send_frame(1);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_len: got %0d required %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d: got %h required %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_escape();
    test_backpressure();
    test_empty();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
